// File: rtl/mips_instr_encoder_pkg.sv
// Shared ISA definitions for the MIPS subset encoder.
// Contents: op classes, opcode and funct constants, and field-packing helpers.
package mips_isa_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_SLT  = 4'd4,
        OP_ADDI = 4'd5,
        OP_LW   = 4'd6,
        OP_SW   = 4'd7,
        OP_BEQ  = 4'd8,
        OP_J    = 4'd9
    } op_class_t;

    localparam logic [5:0] OPC_R    = 6'b000000;
    localparam logic [5:0] OPC_ADDI = 6'b001000;
    localparam logic [5:0] OPC_LW   = 6'b100011;
    localparam logic [5:0] OPC_SW   = 6'b101011;
    localparam logic [5:0] OPC_BEQ  = 6'b000100;
    localparam logic [5:0] OPC_J    = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    typedef struct packed {
        logic [3:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [25:0] imm;
    } instr_fields_t;

    // in_op is a raw 4-bit field, so codes 10..15 can arrive and must be flagged.
    function automatic logic is_legal_op(input logic [3:0] op);
        return op <= OP_J;
    endfunction

    function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [5:0] funct);
        return {OPC_R, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] opc, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

endpackage

// File: rtl/mips_instr_encoder_if.sv
// Handshake bus of the instruction encoder.
// Symbolic instructions enter on the in_* side; packed words and error status leave on the out_* side.
interface mips_instr_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [25:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              err_illegal;
    logic [7:0]        err_count;

    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_addr, err_illegal, err_count
    );

    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, err_illegal, err_count
    );
endinterface

// File: rtl/mips_instr_pack.sv
// Combinational packer: op class plus register and immediate fields in, legal flag and 32-bit MIPS word out.
// The decoder bench can reuse this module as its reference model.
module mips_instr_pack
    import mips_isa_pkg::*;
(
    input  instr_fields_t i_fields,
    output logic          o_legal,
    output logic [31:0]   o_instr
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        o_legal = 1'b1;
        o_instr = 32'd0;
        case (i_fields.op)
            OP_ADD:  o_instr = r_word(i_fields.rs, i_fields.rt, i_fields.rd, FUNCT_ADD);
            OP_SUB:  o_instr = r_word(i_fields.rs, i_fields.rt, i_fields.rd, FUNCT_SUB);
            OP_AND:  o_instr = r_word(i_fields.rs, i_fields.rt, i_fields.rd, FUNCT_AND);
            OP_OR:   o_instr = r_word(i_fields.rs, i_fields.rt, i_fields.rd, FUNCT_OR);
            OP_SLT:  o_instr = r_word(i_fields.rs, i_fields.rt, i_fields.rd, FUNCT_SLT);
            OP_ADDI: o_instr = i_word(OPC_ADDI, i_fields.rs, i_fields.rt, i_fields.imm[15:0]);
            OP_LW:   o_instr = i_word(OPC_LW, i_fields.rs, i_fields.rt, i_fields.imm[15:0]);
            OP_SW:   o_instr = i_word(OPC_SW, i_fields.rs, i_fields.rt, i_fields.imm[15:0]);
            OP_BEQ:  o_instr = i_word(OPC_BEQ, i_fields.rs, i_fields.rt, i_fields.imm[15:0]);
            OP_J:    o_instr = {OPC_J, i_fields.imm};
            default: o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_instr_encoder.sv
// Two-stage pipelined MIPS instruction encoder.
// Stage 1 holds raw fields; stage 2 holds the packed word and its instruction-memory address.
module mips_instr_encoder
    import mips_isa_pkg::*;
#(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    mips_instr_encoder_if.slave  bus
);

    logic              r_s1_valid;
    logic              r_s1_legal;
    instr_fields_t     r_s1;
    logic              r_out_valid;
    logic [31:0]       r_out_instr;
    logic [ADDR_W-1:0] r_addr;
    logic              r_err_illegal;
    logic [7:0]        r_err_count;

    logic              w_s1_adv;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_out_hs;
    logic              w_pack_legal;
    logic [31:0]       w_pack_instr;
    logic              w_emit;
    logic              w_drop;

    mips_instr_pack u_pack (
        .i_fields (r_s1),
        .o_legal  (w_pack_legal),
        .o_instr  (w_pack_instr)
    );

    assign w_s1_adv   = r_s1_valid && (!r_out_valid || bus.out_ready);
    assign w_in_ready = (!r_s1_valid || w_s1_adv) && !clr;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_out_hs   = r_out_valid && bus.out_ready;
    assign w_emit     = w_s1_adv && r_s1_legal && w_pack_legal;
    assign w_drop     = w_s1_adv && !w_emit;

    // NOTE: all state below uses <= so each register samples pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_legal <= 1'b0;
            r_s1       <= '0;
        end else if (clr) begin
            r_s1_valid <= 1'b0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_legal <= is_legal_op(bus.in_op);
            r_s1       <= '{op: bus.in_op, rs: bus.in_rs, rt: bus.in_rt,
                            rd: bus.in_rd, imm: bus.in_imm};
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    // A dropped illegal op leaves stage 2 and the address untouched apart from a normal drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid   <= 1'b0;
            r_out_instr   <= 32'd0;
            r_addr        <= BASE_ADDR;
            r_err_illegal <= 1'b0;
            r_err_count   <= 8'd0;
        end else if (clr) begin
            r_out_valid   <= 1'b0;
            r_addr        <= BASE_ADDR;
            r_err_illegal <= 1'b0;
            r_err_count   <= 8'd0;
        end else begin
            if (w_emit) begin
                r_out_valid <= 1'b1;
                r_out_instr <= w_pack_instr;
            end else if (w_out_hs) begin
                r_out_valid <= 1'b0;
            end
            if (w_out_hs) begin
                r_addr <= r_addr + ADDR_W'(1);
            end
            r_err_illegal <= w_drop;
            if (w_drop && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_instr   = r_out_instr;
    assign bus.out_addr    = r_addr;
    assign bus.err_illegal = r_err_illegal;
    assign bus.err_count   = r_err_count;

endmodule

// File: doc/mips_instr_encoder.md
Name: mips_instr_encoder

Overview:
Pipelined instruction encoder. It is the writer-side counterpart of the MIPS control decoder. It accepts symbolic instructions (op class plus register/immediate fields) over a valid/ready handshake and packs them into 32-bit MIPS words. Each word leaves with an auto-incrementing instruction-memory word address, so a loader or testbench can fill instruction memory for the supported subset: add, sub, and, or, slt, addi, lw, sw, beq, j.

Parameters:
ADDR_W, 8, width of the instruction-memory word address.
BASE_ADDR, 0, address value loaded on reset and on clr.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous; empties the pipeline, reloads address to BASE_ADDR, zeroes err_count
in_valid  input  1  input instruction valid
in_ready  output  1  encoder can accept
in_op  input  4  op class (package enum)
in_rs  input  5  rs field
in_rt  input  5  rt field
in_rd  input  5  rd field (R-type only)
in_imm  input  26  imm16 in [15:0] for I-type; target26 for j
out_valid  output  1  encoded word valid
out_ready  input  1  consumer accepts
out_instr  output  32  encoded instruction
out_addr  output  ADDR_W  word address for out_instr
err_illegal  output  1  one-cycle pulse: an unsupported in_op was dropped
err_count  output  8  saturating count of dropped ops

Behaviour:
- Reset (rst_n=0, async): s1_valid=0, out_valid=0, out_instr=0, out_addr=BASE_ADDR, err_illegal=0, err_count=0.
- Input handshake occurs when in_valid && in_ready. in_ready = !s1_valid || s1_adv.
- Stage 1 registers the raw fields and a legal flag. Stage 2 (output register) holds the encoded word.
- s1_adv = s1_valid && (!out_valid || out_ready).
- Latency: an accepted instruction is on out_valid 2 cycles after acceptance when out_ready=1. Throughput is 1 word per cycle.
- Backpressure: out_valid && !out_ready holds out_instr and out_addr stable. Stage 1 holds. in_ready drops once stage 1 is full. No data is lost and no data is duplicated.
- Encoding (shamt=0 for R-type):
  - R-type: {000000, rs, rt, rd, 00000, funct}. funct: add 100000, sub 100010, and 100100, or 100101, slt 101010.
  - addi: {001000, rs, rt, imm[15:0]}.
  - lw: {100011, rs, rt, imm[15:0]}.
  - sw: {101011, rs, rt, imm[15:0]}.
  - beq: {000100, rs, rt, imm[15:0]}.
  - j: {000010, imm[25:0]}.
- Unused input fields are ignored. For I-type ops, imm[25:16] is ignored.
- Illegal op (enum value outside the 10 codes):
  - Accepted normally.
  - In stage 1, when it would advance, it is discarded and produces no output word.
  - err_illegal pulses for that cycle.
  - err_count increments and saturates at 255.
  - out_addr does not advance.
- Address: out_addr is the address of the word currently in stage 2. It increments by 1 (mod 2^ADDR_W, wrapping to 0, not to BASE_ADDR) on the cycle after each output handshake, so the next word gets the next address.
- Simultaneous events:
  - Output handshake and new stage-1 advance in the same cycle: the new word loads and the address increments in the same edge.
  - clr has priority over all handshakes. The in-flight words are dropped, and in_ready is 0 during the clr cycle.
- Reset mid-stream: all in-flight words are lost, and the state is as at reset.

Decomposition:
- Package mips_isa_pkg holds:
  - the op_class enum: ADD=0, SUB=1, AND=2, OR=3, SLT=4, ADDI=5, LW=6, SW=7, BEQ=8, J=9;
  - opcode constants (R 000000, ADDI 001000, LW 100011, SW 101011, BEQ 000100, J 000010);
  - funct constants.
- Sub-module mips_instr_pack is purely combinational: op_class and fields in, {legal, instr[31:0]} out. It is instantiated between stage 1 and stage 2. The decoder's bench can reuse it as a reference model.

Test Plan:
- ADD rs=1 rt=2 rd=3, out_ready=1 -> out_instr=0x00221820 at out_addr=0, exactly 2 cycles after acceptance.
- Back-to-back stream: LW rs=29 rt=8 imm=4, SW rs=0 rt=9 imm=8, BEQ rs=1 rt=2 imm=0xFFFF, J imm=0x10 -> 0x8FA80004, 0xAC090008, 0x1022FFFF, 0x08000010 at addresses 0,1,2,3 on consecutive cycles.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles while 3 words are offered, then release.
  - Response: out_instr is stable while stalled, in_ready=0 after the 2nd acceptance, and all 3 words emerge in order with no gaps or duplicates.
- Illegal op:
  - Stimulus: in_op=12 between two ADDIs (ADDI rs=0 rt=4 imm=0x0005 -> 0x20040005).
  - Response: one err_illegal pulse, err_count=1, the two ADDIs emitted at consecutive addresses 0 and 1.
- Wrap with ADDR_W=2:
  - Stimulus: emit 5 words.
  - Response: out_addr sequence 0,1,2,3,0.
- clr and async reset:
  - Stimulus: assert clr with 2 words in flight.
  - Response: out_valid=0 next cycle, out_addr=BASE_ADDR, err_count=0.
  - Stimulus: pulse rst_n low mid-stall.
  - Response: outputs return to reset values immediately, without waiting for a clock edge.
